// File: rtl/axis_prefetch_fifo.sv
// AXI-Stream FIFO with registered handshake outputs on both sides.
// The head entry is presented from storage, so every output is driven only by flops.
module axis_prefetch_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEPTH      = 4
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
   input  logic [USER_WIDTH-1:0]        s_axis_tuser,
   input  logic                         s_axis_tlast,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   output logic [DATA_WIDTH-1:0]        m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
   output logic [USER_WIDTH-1:0]        m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int WORD_W = 1 + USER_WIDTH + KEEP_W + DATA_WIDTH;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = $clog2(DEPTH + 1);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic              push, pop;
   logic [WORD_W-1:0] wr_word;

   always_comb begin
      push     = s_axis_tvalid && s_ready_q;
      pop      = m_valid_q && m_axis_tready;
      wr_word  = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
      // Handshake flags are derived from the next level so they are valid one edge later.
      s_ready_d = (level_d != LVL_W'(DEPTH));
      m_valid_d = (level_d != '0);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
      end
   end

   // Storage is intentionally left out of reset; payload is ignored while tvalid is low.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= wr_word;
   end

   assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q];
   assign s_axis_tready = s_ready_q;
   assign m_axis_tvalid = m_valid_q;
   assign level         = level_q;

endmodule

// File: tb/tb_axis_prefetch_fifo.sv
// Directed and randomised-handshake checks for axis_prefetch_fifo at DEPTH=4.
module tb_axis_prefetch_fifo;

   localparam int DW = 32;
   localparam int UW = 1;
   localparam int DP = 4;

   logic          aclk = 1'b0;
   logic          areset;
   logic [DW-1:0] s_tdata;
   logic [3:0]    s_tkeep;
   logic [UW-1:0] s_tuser;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [3:0]    m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [2:0]    level;

   int errors = 0;
   int checks = 0;

   axis_prefetch_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DP)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .level(level)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d);
      s_tvalid = v;
      s_tdata  = d;
      s_tkeep  = 4'hF;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   initial begin
      logic [31:0] sb[$];
      logic [31:0] exp_word;
      logic        do_push, do_pop;
      int          mlvl;
      int          nbeats;

      areset = 1'b1;
      m_tready = 1'b0;
      drive(1'b0, 32'h0);

      // Reset state
      tick(); tick();
      chk("rst_level", level, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_sready", s_tready, 0);
      areset = 1'b0;
      tick();
      chk("rst_release_sready", s_tready, 1);
      chk("rst_release_mvalid", m_tvalid, 0);

      // Single beat into empty: one-cycle latency, all fields carried, stable when stalled
      s_tvalid = 1'b1; s_tdata = 32'hA5; s_tkeep = 4'hF; s_tuser = 1'b1; s_tlast = 1'b1;
      tick();
      drive(1'b0, 32'hDEAD_BEEF);
      chk("lat_mvalid", m_tvalid, 1);
      chk("lat_tdata", m_tdata, 32'hA5);
      chk("lat_tkeep", m_tkeep, 4'hF);
      chk("lat_tuser", m_tuser, 1);
      chk("lat_tlast", m_tlast, 1);
      chk("lat_level", level, 1);
      tick(); tick();
      chk("stall_mvalid", m_tvalid, 1);
      chk("stall_tdata", m_tdata, 32'hA5);
      chk("stall_tlast", m_tlast, 1);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk("pop1_mvalid", m_tvalid, 0);
      chk("pop1_level", level, 0);

      // Fill to DEPTH with downstream stalled
      drive(1'b1, 32'h11); tick(); chk("fill_l1", level, 1);
      drive(1'b1, 32'h22); tick(); chk("fill_l2", level, 2);
      drive(1'b1, 32'h33); tick(); chk("fill_l3", level, 3); chk("fill_sready3", s_tready, 1);
      drive(1'b1, 32'h44); tick(); chk("fill_l4", level, 4); chk("full_sready", s_tready, 0);
      drive(1'b1, 32'h55); tick();
      chk("full_hold_level", level, 4);
      chk("full_hold_sready", s_tready, 0);
      chk("full_head", m_tdata, 32'h11);

      // Pop at full with tvalid high: no push that edge, then level 3 -> 4
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk("fullpop_level", level, 3);
      chk("fullpop_sready", s_tready, 1);
      chk("fullpop_head", m_tdata, 32'h22);
      tick();
      drive(1'b0, 32'h0);
      chk("refill_level", level, 4);
      chk("refill_sready", s_tready, 0);

      // Drain in order
      m_tready = 1'b1;
      chk("drain_22", m_tdata, 32'h22); tick();
      chk("drain_33", m_tdata, 32'h33); tick();
      chk("drain_44", m_tdata, 32'h44); tick();
      chk("drain_55", m_tdata, 32'h55); tick();
      chk("drain_level", level, 0);
      chk("drain_mvalid", m_tvalid, 0);

      // Streaming with both sides ready: one beat per cycle, level stays 1
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 32'(i));
         tick();
         chk("stream_data", m_tdata, 64'(i));
         chk("stream_level", level, 1);
         chk("stream_mvalid", m_tvalid, 1);
      end
      drive(1'b0, 32'h0);
      tick();
      chk("stream_end_level", level, 0);
      chk("stream_end_mvalid", m_tvalid, 0);

      // Reset with a 3-beat partial packet stored
      m_tready = 1'b0;
      drive(1'b1, 32'hA1); tick();
      drive(1'b1, 32'hA2); tick();
      drive(1'b1, 32'hA3); tick();
      drive(1'b0, 32'h0);
      chk("prerst_level", level, 3);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      chk("midrst_level", level, 0);
      chk("midrst_mvalid", m_tvalid, 0);
      chk("midrst_sready", s_tready, 0);
      tick();
      chk("postrst_sready", s_tready, 1);
      chk("postrst_mvalid", m_tvalid, 0);
      drive(1'b1, 32'hB1); tick();
      drive(1'b0, 32'h0);
      chk("postrst_level", level, 1);
      chk("postrst_head", m_tdata, 32'hB1);
      m_tready = 1'b1;
      tick();
      chk("postrst_drained", level, 0);

      // Random handshakes with scoreboard; distinct payload per accepted beat
      mlvl = 0;
      nbeats = 0;
      for (int c = 0; c < 1500; c++) begin
         drive(1'($urandom_range(0, 1)), 32'hC000_0000 + 32'(nbeats));
         m_tready = 1'($urandom_range(0, 1));
         chk("rnd_mvalid", m_tvalid, (mlvl != 0));
         chk("rnd_sready", s_tready, (mlvl != DP));
         do_push = s_tvalid && s_tready;
         do_pop  = m_tvalid && m_tready;
         if (do_pop) begin
            if (sb.size() == 0) begin
               chk("rnd_pop_on_empty_model", 1, 0);
            end else begin
               exp_word = sb.pop_front();
               chk("rnd_data", m_tdata, exp_word);
            end
         end
         if (do_push) begin
            sb.push_back(s_tdata);
            nbeats++;
         end
         tick();
         mlvl = mlvl + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
         chk("rnd_level", level, 64'(mlvl));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
